// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus port between instruction fetch (IF) and load/store (D).
// One outstanding transaction; D has priority with a bounded streak so IF cannot starve.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [31:0]             if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic                    drop_q, drop_d;
  logic [SW-1:0]           streak_q, streak_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH/8-1:0] mem_wmask_q, mem_wmask_d;
  logic                    if_rvalid_q, if_rvalid_d;
  logic [31:0]             if_rdata_q, if_rdata_d;
  logic                    d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;

  logic streak_full;
  logic sel_d;
  logic sel_if;

  assign streak_full = (streak_q == SW'(MAX_DSTREAK));
  assign sel_d       = d_req && !(if_req && streak_full);
  assign sel_if      = !sel_d && if_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    streak_d    = streak_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (sel_d) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wmask_d = d_wmask;
          // The streak only grows while IF is actually being held off.
          streak_d    = if_req ? streak_q + SW'(1) : '0;
          state_d     = ISSUE;
        end else if (sel_if) begin
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          streak_d    = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_q == OWN_IF && if_flush) drop_d = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (owner_q == OWN_IF && if_flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          state_d     = IDLE;
          drop_d      = 1'b0;
          d_rvalid_d  = (owner_q == OWN_D);
          // A flush arriving with the response itself must also suppress it.
          if_rvalid_d = (owner_q == OWN_IF) && !drop_q && !if_flush;
          d_rdata_d   = mem_rdata;
          if_rdata_d  = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      streak_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      streak_q    <= streak_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign if_gnt    = mem_req && mem_gnt && (owner_q == OWN_IF);
  assign d_gnt     = mem_req && mem_gnt && (owner_q == OWN_D);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0] if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [DW/8-1:0] d_wmask;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Stimulus controls
  bit model_on, auto_bus, rand_bus;
  int unsigned if_rate, d_rate, flush_rate;
  int cfg_gnt, cfg_rv, gcnt, rcnt;
  logic [63:0] cfg_rdata;
  bit rsp_pend, if_gnt_seen, d_gnt_seen;

  // Reference model: one transaction record plus the D-streak count
  typedef enum int {PH_IDLE, PH_ISSUE, PH_WAIT} ph_t;
  ph_t ph;
  bit t_d, t_we, t_flushed;
  logic [63:0] t_addr, t_wdata;
  logic [7:0] t_wmask;
  int streak;
  bit due_if, due_d;
  logic [31:0] due_ifdata;
  logic [63:0] due_ddata;
  int n_ifv, n_dv;
  bit glog[$];

  typedef struct {
    bit is_d; bit we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask;
    int gnt_dly; int rv_dly; logic [63:0] rdata; int flush_cyc;
    bit exp_rv; logic [63:0] exp_rdata;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; streak = 0; due_if = 0; due_d = 0; t_flushed = 0;
    t_d = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_wmask = '0;
  endtask

  // Advance to just after the next rising edge and update requesters and bus.
  task automatic adv();
    @(posedge clk); #1;
    if (if_gnt_seen) begin if_gnt_seen = 0; if_req = 0; end
    if (d_gnt_seen) begin d_gnt_seen = 0; d_req = 0; end
    if (!if_req && if_rate > 0 && $urandom_range(99) < if_rate) begin
      if_req = 1; if_addr = {$urandom, $urandom} & ~64'h3;
    end
    if (!d_req && d_rate > 0 && $urandom_range(99) < d_rate) begin
      d_req = 1; d_we = 1'($urandom_range(1)); d_addr = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom}; d_wmask = 8'($urandom);
    end
    if_flush = (flush_rate > 0) && ($urandom_range(99) < flush_rate);
    if (auto_bus) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (rsp_pend) begin
        if (rcnt == 0) begin
          mem_rvalid = 1; mem_rdata = rand_bus ? {$urandom, $urandom} : cfg_rdata; rsp_pend = 0;
        end else rcnt--;
      end else if (mem_req) begin
        if (gcnt == 0) begin
          mem_gnt = 1; rsp_pend = 1;
          rcnt = rand_bus ? int'($urandom_range(3)) : cfg_rv;
          gcnt = rand_bus ? int'($urandom_range(3)) : cfg_gnt;
        end else gcnt--;
      end
    end
  endtask

  // Sample outputs mid-cycle and compare against the reference model.
  task automatic chk_cycle();
    #3;
    if (model_on) begin
      chk("if_rvalid", if_rvalid, due_if);
      chk("d_rvalid", d_rvalid, due_d);
      if (due_if) chk("if_rdata", if_rdata, due_ifdata);
      if (due_d) chk("d_rdata", d_rdata, due_ddata);
      due_if = 0; due_d = 0;
      chk("mem_req", mem_req, ph == PH_ISSUE);
      chk("if_gnt", if_gnt, ph == PH_ISSUE && mem_gnt && !t_d);
      chk("d_gnt", d_gnt, ph == PH_ISSUE && mem_gnt && t_d);
      if (ph == PH_ISSUE) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_we", mem_we, t_we);
        if (t_d) begin
          chk("mem_wdata", mem_wdata, t_wdata);
          chk("mem_wmask", mem_wmask, t_wmask);
        end
      end
      if (ph != PH_IDLE && !t_d && if_flush) t_flushed = 1;
      case (ph)
        PH_IDLE: if (if_req || d_req) begin
          t_d = d_req && !(if_req && streak >= MAXS);
          if (t_d) begin
            streak = if_req ? streak + 1 : 0;
            t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_wmask = d_wmask;
          end else begin
            streak = 0; t_we = 0; t_addr = if_addr;
          end
          t_flushed = 0; ph = PH_ISSUE;
        end
        PH_ISSUE: if (mem_gnt) begin glog.push_back(t_d); ph = PH_WAIT; end
        PH_WAIT: if (mem_rvalid) begin
          if (t_d) begin due_d = 1; due_ddata = mem_rdata; end
          else begin
            due_if = !t_flushed;
            due_ifdata = t_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
          ph = PH_IDLE;
        end
        default: ph = PH_IDLE;
      endcase
    end
    if (if_gnt) if_gnt_seen = 1;
    if (d_gnt) d_gnt_seen = 1;
    if (if_rvalid) n_ifv++;
    if (d_rvalid) n_dv++;
    cyc++;
  endtask

  task automatic run_vec(input vec_t v);
    int ifv0, dv0;
    cfg_gnt = v.gnt_dly; cfg_rv = v.rv_dly; cfg_rdata = v.rdata; gcnt = v.gnt_dly;
    ifv0 = n_ifv; dv0 = n_dv;
    adv();
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    if_flush = (v.flush_cyc == 0);
    chk_cycle();
    for (int c = 1; c <= 4 + v.gnt_dly + v.rv_dly; c++) begin
      adv();
      if_flush = (v.flush_cyc == c);
      chk_cycle();
      if (c == 1 + v.gnt_dly) chk("vec_gnt", v.is_d ? d_gnt : if_gnt, 1);
      if (c == 3 + v.gnt_dly + v.rv_dly) begin
        chk("vec_rvalid", v.is_d ? d_rvalid : if_rvalid, v.exp_rv);
        if (v.exp_rv) chk("vec_rdata", v.is_d ? d_rdata : 64'(if_rdata), v.exp_rdata);
      end
    end
    chk("vec_pulses", 64'((n_ifv - ifv0) + (n_dv - dv0)), 64'(v.exp_rv));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //           is_d we addr                 wdata                  wmask g  r  rdata                  flush rv exp_rdata
    vt[0] = '{1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'h00, 0, 0, 64'hAAAA_BBBB_1111_2222, -1, 1'b1, 64'hAAAA_BBBB};
    vt[1] = '{1'b0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, 1, 2, 64'h0123_4567_89AB_CDEF, -1, 1'b1, 64'h89AB_CDEF};
    vt[2] = '{1'b0, 1'b0, 64'h0000_0100, 64'h0, 8'h00, 0, 5, 64'hFEED_FACE_CAFE_BABE, 2, 1'b0, 64'h0};
    vt[3] = '{1'b0, 1'b0, 64'h0000_0104, 64'h0, 8'h00, 0, 0, 64'h1122_3344_5566_7788, -1, 1'b1, 64'h1122_3344};
    vt[4] = '{1'b1, 1'b1, 64'h0000_2000, 64'hDEAD_BEEF_00C0_FFEE, 8'h0F, 3, 0, 64'h5A5A_5A5A_A5A5_A5A5, -1, 1'b1, 64'h5A5A_5A5A_A5A5_A5A5};
    vt[5] = '{1'b1, 1'b0, 64'h0000_1000, 64'h0, 8'h00, 0, 1, 64'h0F0E_0D0C_0B0A_0908, -1, 1'b1, 64'h0F0E_0D0C_0B0A_0908};
    vt[6] = '{1'b0, 1'b0, 64'h0000_0200, 64'h0, 8'h00, 0, 0, 64'h1111_2222_3333_4444, 0, 1'b1, 64'h3333_4444};
    vt[7] = '{1'b1, 1'b0, 64'h0000_3008, 64'h0, 8'h00, 0, 2, 64'h7777_6666_5555_4444, 2, 1'b1, 64'h7777_6666_5555_4444};
    vt[8] = '{1'b0, 1'b0, 64'h0000_0300, 64'h0, 8'h00, 0, 1, 64'h9999_8888_7777_6666, 3, 1'b0, 64'h0};
    vt[9] = '{1'b0, 1'b0, 64'h0000_0404, 64'h0, 8'h00, 2, 0, 64'h1357_9BDF_2468_ACE0, 1, 1'b0, 64'h0};

    rst = 1; if_req = 0; if_addr = '0; if_flush = 0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wmask = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    model_on = 0; auto_bus = 0; rand_bus = 0; if_rate = 0; d_rate = 0; flush_rate = 0;
    cfg_gnt = 0; cfg_rv = 0; cfg_rdata = '0; gcnt = 0; rcnt = 0; rsp_pend = 0;
    if_gnt_seen = 0; d_gnt_seen = 0; n_ifv = 0; n_dv = 0;
    model_reset();

    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_on = 1; auto_bus = 1;

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Simultaneous requests: D first, then IF, one response each
    cfg_gnt = 0; cfg_rv = 0; gcnt = 0; cfg_rdata = 64'hC0DE_0001_C0DE_0002;
    glog.delete();
    begin
      int ifv0, dv0;
      ifv0 = n_ifv; dv0 = n_dv;
      adv();
      if_req = 1; if_addr = 64'h2000; d_req = 1; d_we = 0; d_addr = 64'h1000;
      chk_cycle();
      repeat (8) begin adv(); chk_cycle(); end
      chk("both_grants", 64'(glog.size()), 2);
      chk("both_first_d", (glog.size() > 0) ? glog[0] : 1'b0, 1);
      chk("both_second_if", (glog.size() > 1) ? glog[1] : 1'b1, 0);
      chk("both_if_pulses", 64'(n_ifv - ifv0), 1);
      chk("both_d_pulses", 64'(n_dv - dv0), 1);
    end

    // Both held continuously: grant pattern D D D D IF repeating
    glog.delete();
    if_rate = 100; d_rate = 100;
    repeat (34) begin adv(); chk_cycle(); end
    if_rate = 0; d_rate = 0;
    chk("streak_grant_count", 64'(glog.size() >= 10), 1);
    for (int i = 0; i < 10; i++)
      if (i < glog.size()) chk("streak_pattern", glog[i], (i % 5 == 4) ? 1'b0 : 1'b1);
    repeat (14) begin adv(); chk_cycle(); end

    // Reset asserted while waiting on the bus; late response afterwards is ignored
    cfg_gnt = 0; cfg_rv = 20; gcnt = 0;
    adv(); if_req = 1; if_addr = 64'h40; chk_cycle();
    repeat (3) begin adv(); chk_cycle(); end
    auto_bus = 0; model_on = 0; rsp_pend = 0; mem_gnt = 0; mem_rvalid = 0;
    chk("pre_rst_addr", mem_addr, 64'h40);
    #1 rst = 1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    chk("midrst_if_rvalid", if_rvalid, 0);
    chk("midrst_d_rvalid", d_rvalid, 0);
    adv(); rst = 0; chk_cycle();
    adv(); mem_rvalid = 1; mem_rdata = 64'hBAD0_BAD1_BAD2_BAD3; chk_cycle();
    chk("late_rsp_mem_req", mem_req, 0);
    adv(); mem_rvalid = 0; chk_cycle();
    chk("late_rsp_if_rvalid", if_rvalid, 0);
    chk("late_rsp_d_rvalid", d_rvalid, 0);
    chk("late_rsp_mem_req2", mem_req, 0);
    model_reset(); gcnt = 0; rsp_pend = 0; model_on = 1; auto_bus = 1;

    // Randomized traffic against the reference model
    rand_bus = 1; if_rate = 40; d_rate = 40; flush_rate = 10;
    repeat (3000) begin adv(); chk_cycle(); end
    if_rate = 0; d_rate = 0; flush_rate = 0;
    repeat (30) begin adv(); chk_cycle(); end
    chk("drain_idle", 64'(ph == PH_IDLE), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
